writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 64, which sets the datapath width in bits.
REQ-002 The block SHALL have the parameter REG_AW, default 5, which sets the register-address width.
REQ-003 The block SHALL have the parameter LINK_REG, default 30, which sets the BL destination register index.
REQ-004 The block SHALL have the parameter ZERO_REG, default 31, which sets the zero-register index; writes to it are discarded.
REQ-005 The block SHALL have the parameter CNT_W, default 32, which sets the retire-counter width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them.
REQ-007 Port clk  input  1: rising-edge clock.
REQ-008 Port reset_n  input  1: asynchronous, active-low reset.
REQ-009 Port mem_valid  input  1: the MEM-stage entry is a real instruction.
REQ-010 Port mem_mem_data  input  DATA_W: raw load data, right-aligned.
REQ-011 Port mem_alu_result  input  DATA_W: ALU result.
REQ-012 Port mem_bl_write_data  input  DATA_W: return address (PC+4) for BL.
REQ-013 Port mem_rd  input  REG_AW: destination register.
REQ-014 Port mem_control  input  4: {RegWrite, MemToReg, SetFlags, BL}, MSB first.
REQ-015 Port mem_ld_size  input  2: load size; 0=byte, 1=half, 2=word, 3=double.
REQ-016 Port mem_ld_signed  input  1: sign-extend the load (LDURSW-style).
REQ-017 Port mem_flags  input  4: NZCV produced by the instruction.
REQ-018 Port stall  input  1: hold the WB register.
REQ-019 Port flush  input  1: invalidate the WB register.
REQ-020 Port RegWrite_out  output  1: register-file write enable.
REQ-021 Port write_reg_out  output  REG_AW: register-file write address.
REQ-022 Port write_data_out  output  DATA_W: register-file write data.
REQ-023 Port fwd_valid  output  1: forwarding path valid; equal to RegWrite_out.
REQ-024 Port flags_out  output  4: committed NZCV register.
REQ-025 Port retired_count  output  CNT_W: count of retired instructions.

Function
REQ-026 The block SHALL hold a single registered WB entry: valid bit, data fields, rd, control, ld_size, ld_signed, flags.
REQ-027 At each rising edge, the WB entry SHALL be updated in this priority order:
- flush: valid is cleared to 0 and the data fields are don't-care;
- else stall: the entry holds;
- else: the entry loads all mem_* inputs, with valid taking mem_valid.
REQ-028 All WB outputs SHALL be combinational from the WB entry, giving 1-cycle latency from the MEM inputs to the outputs.
REQ-029 Load data SHALL be mem_mem_data truncated to the mem_ld_size width, then sign-extended if mem_ld_signed is 1, otherwise zero-extended, to DATA_W.
REQ-030 Size 3 SHALL pass load data unchanged; mem_ld_signed is ignored for size 3.
REQ-031 The selected data SHALL be the extended load data when MemToReg=1, otherwise the ALU result.
REQ-032 When BL=1, write_reg_out SHALL be LINK_REG and write_data_out SHALL be the BL data, regardless of MemToReg.
REQ-033 When BL=0, write_reg_out SHALL be the entry rd and write_data_out SHALL be the selected data.
REQ-034 RegWrite_out SHALL be valid AND RegWrite AND (write_reg_out != ZERO_REG).
REQ-035 An entry retires on a rising edge where valid=1, stall=0 and flush=0.
REQ-036 On retire with SetFlags=1, flags_out SHALL load the entry flags; otherwise flags_out holds.
REQ-037 On retire, retired_count SHALL increment by 1 and wrap modulo 2^CNT_W.
REQ-038 A stalled entry SHALL keep its outputs asserted each cycle, but SHALL NOT update flags_out or retired_count until it retires.
REQ-039 When flush and stall are both asserted, flush SHALL win; an entry that is valid on that edge does not retire.

Reset
REQ-040 While reset_n=0, asynchronously: WB valid=0, flags_out=0, retired_count=0.
REQ-041 While reset_n=0, RegWrite_out=0 and fwd_valid=0.
REQ-042 While reset_n=0, write_reg_out and write_data_out SHALL be 0.
REQ-043 Deassertion of reset_n SHALL take effect at the next rising edge; the first capture occurs at that edge.
REQ-044 Reset asserted mid-stall SHALL discard the held entry with no retire.

Verification
REQ-045 ALU op: mem_valid=1, control=1000, rd=5, alu=0x1234 -> next cycle RegWrite_out=1, reg=5, data=0x1234; retired_count=1 after the following edge.
REQ-046 LDURSW: control=1100, size=2, signed=1, mem_data=0x0000_0000_8000_0001 -> data=0xFFFF_FFFF_8000_0001; the same with signed=0 -> 0x0000_0000_8000_0001; size=0, data 0xFF, signed=1 -> all ones.
REQ-047 BL: control=1001, rd=7, bl_data=0x400 -> reg=30, data=0x400; write to rd=31 with RegWrite=1 -> RegWrite_out=0, but the entry still retires.
REQ-048 SetFlags: control=0010, flags=1001 -> flags_out=1001 after retire; a subsequent retire with SetFlags=0 -> flags_out unchanged.
REQ-049 Stall held 3 cycles on a valid entry -> outputs constant and retired_count +1 total; flush+stall on the same edge -> valid=0 and no count.
REQ-050 Counter wrap with CNT_W=4: 16 retires from reset -> retired_count=0; reset_n pulsed low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: one registered WB entry, load extension, result select,
// committed NZCV flags and a retire counter.
//
// Ports:
//   clk, reset_n        rising-edge clock, async active-low reset
//   mem_*               MEM-stage entry captured into the WB register
//   stall, flush        hold / invalidate the WB register (flush wins)
//   RegWrite_out        register-file write enable (never for ZERO_REG)
//   write_reg_out       register-file write address
//   write_data_out      register-file write data
//   fwd_valid           forwarding valid, same as RegWrite_out
//   flags_out           committed NZCV
//   retired_count       retired instruction count, wraps
module writeback_unit #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 30,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_mem_data,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_bl_write_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [3:0]        mem_control,
    input  logic [1:0]        mem_ld_size,
    input  logic              mem_ld_signed,
    input  logic [3:0]        mem_flags,
    input  logic              stall,
    input  logic              flush,
    output logic              RegWrite_out,
    output logic [REG_AW-1:0] write_reg_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic              fwd_valid,
    output logic [3:0]        flags_out,
    output logic [CNT_W-1:0]  retired_count
);

    localparam logic [REG_AW-1:0] LINK = REG_AW'(LINK_REG);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] bl_q, bl_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        fout_q, fout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;
    logic [DATA_W-1:0] ld_ext;

    always_comb begin
        valid_d = valid_q;
        mdata_d = mdata_q;
        alu_d   = alu_q;
        bl_d    = bl_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        flags_d = flags_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = mem_valid;
            mdata_d = mem_mem_data;
            alu_d   = mem_alu_result;
            bl_d    = mem_bl_write_data;
            rd_d    = mem_rd;
            ctrl_d  = mem_control;
            size_d  = mem_ld_size;
            sgn_d   = mem_ld_signed;
            flags_d = mem_flags;
        end
        retire = valid_q & ~stall & ~flush;
        fout_d = fout_q;
        if (retire && ctrl_q[1]) begin
            fout_d = flags_q;
        end
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            mdata_q <= '0;
            alu_q   <= '0;
            bl_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            flags_q <= '0;
            fout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mdata_q <= mdata_d;
            alu_q   <= alu_d;
            bl_q    <= bl_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            flags_q <= flags_d;
            fout_q  <= fout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        unique case (size_q)
            2'd0:    ld_ext = {{(DATA_W-8){sgn_q & mdata_q[7]}},
                               mdata_q[7:0]};
            2'd1:    ld_ext = {{(DATA_W-16){sgn_q & mdata_q[15]}},
                               mdata_q[15:0]};
            2'd2:    ld_ext = {{(DATA_W-32){sgn_q & mdata_q[31]}},
                               mdata_q[31:0]};
            default: ld_ext = mdata_q;
        endcase
    end

    // BL overrides both the address and the MemToReg data select.
    always_comb begin
        if (ctrl_q[0]) begin
            write_reg_out  = LINK;
            write_data_out = bl_q;
        end else begin
            write_reg_out  = rd_q;
            write_data_out = ctrl_q[2] ? ld_ext : alu_q;
        end
        RegWrite_out = valid_q & ctrl_q[3] & (write_reg_out != ZERO);
        fwd_valid    = RegWrite_out;
    end

    assign flags_out     = fout_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit against a behavioural model.
// A second instance with CNT_W=4 checks counter wrap.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [63:0] mem_mem_data = '0;
    logic [63:0] mem_alu_result = '0;
    logic [63:0] mem_bl_write_data = '0;
    logic [4:0]  mem_rd = '0;
    logic [3:0]  mem_control = '0;
    logic [1:0]  mem_ld_size = '0;
    logic        mem_ld_signed = 1'b0;
    logic [3:0]  mem_flags = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        we, fwd, we4, fwd4;
    logic [4:0]  wreg, wreg4;
    logic [63:0] wdata, wdata4;
    logic [3:0]  fout, fout4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_mem_data(mem_mem_data),
        .mem_alu_result(mem_alu_result),
        .mem_bl_write_data(mem_bl_write_data),
        .mem_rd(mem_rd), .mem_control(mem_control),
        .mem_ld_size(mem_ld_size), .mem_ld_signed(mem_ld_signed),
        .mem_flags(mem_flags), .stall(stall), .flush(flush),
        .RegWrite_out(we), .write_reg_out(wreg),
        .write_data_out(wdata), .fwd_valid(fwd),
        .flags_out(fout), .retired_count(cnt)
    );

    writeback_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_mem_data(mem_mem_data),
        .mem_alu_result(mem_alu_result),
        .mem_bl_write_data(mem_bl_write_data),
        .mem_rd(mem_rd), .mem_control(mem_control),
        .mem_ld_size(mem_ld_size), .mem_ld_signed(mem_ld_signed),
        .mem_flags(mem_flags), .stall(stall), .flush(flush),
        .RegWrite_out(we4), .write_reg_out(wreg4),
        .write_data_out(wdata4), .fwd_valid(fwd4),
        .flags_out(fout4), .retired_count(cnt4)
    );

    // model state: the WB entry plus committed state
    logic        e_valid;
    logic [63:0] e_mem, e_alu, e_bl;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctrl, e_flags;
    logic [1:0]  e_size;
    logic        e_sgn;
    logic [3:0]  m_flags;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ext(input logic [63:0] d,
                                        input logic [1:0] size,
                                        input logic sgn);
        int bits;
        logic [63:0] mask, v;
        if (size == 2'd3) return d;
        bits = 8 << size;
        mask = (64'd1 << bits) - 64'd1;
        v = d & mask;
        if (sgn && d[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_reset();
        e_valid = 0; e_mem = 0; e_alu = 0; e_bl = 0; e_rd = 0;
        e_ctrl = 0; e_flags = 0; e_size = 0; e_sgn = 0;
        m_flags = 0; m_cnt = 0;
    endtask

    task automatic check_all();
        logic [4:0]  xr;
        logic [63:0] xd;
        logic        xw;
        xr = e_ctrl[0] ? 5'd30 : e_rd;
        xd = e_ctrl[0] ? e_bl :
             (e_ctrl[2] ? ext(e_mem, e_size, e_sgn) : e_alu);
        xw = e_valid && e_ctrl[3] && xr != 5'd31;
        check("we", we, xw);
        check("fwd", fwd, xw);
        if (e_valid) begin
            check("reg", wreg, xr);
            check("data", wdata, xd);
        end
        check("flags", fout, m_flags);
        check("cnt", cnt, m_cnt);
        check("cnt4", cnt4, m_cnt % 16);
    endtask

    task automatic tick();
        if (e_valid && !stall && !flush) begin
            if (e_ctrl[1]) m_flags = e_flags;
            m_cnt++;
        end
        if (flush) e_valid = 0;
        else if (!stall) begin
            e_valid = mem_valid; e_mem = mem_mem_data;
            e_alu = mem_alu_result; e_bl = mem_bl_write_data;
            e_rd = mem_rd; e_ctrl = mem_control; e_size = mem_ld_size;
            e_sgn = mem_ld_signed; e_flags = mem_flags;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] c,
                         input logic [4:0] rd, input logic [63:0] alu,
                         input logic [63:0] md, input logic [63:0] bl,
                         input logic [1:0] sz, input logic sg,
                         input logic [3:0] fl);
        mem_valid = v; mem_control = c; mem_rd = rd;
        mem_alu_result = alu; mem_mem_data = md;
        mem_bl_write_data = bl; mem_ld_size = sz;
        mem_ld_signed = sg; mem_flags = fl;
    endtask

    task automatic idle();
        drive(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        model_reset();
        check("rst_we", we, 0);
        check("rst_fwd", fwd, 0);
        check("rst_reg", wreg, 0);
        check("rst_data", wdata, 0);
        check("rst_flags", fout, 0);
        check("rst_cnt", cnt, 0);
        stall = 0; flush = 0; idle();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    logic [63:0] hold_d;
    logic [4:0]  hold_r;

    initial begin
        model_reset();
        idle();
        #2;
        do_reset();

        // ALU op
        drive(1, 4'b1000, 5, 64'h1234, 0, 0, 0, 0, 0);
        tick();
        check("alu_we", we, 1);
        check("alu_reg", wreg, 5);
        check("alu_data", wdata, 64'h1234);
        idle();
        tick();
        check("alu_cnt", cnt, 1);

        // loads
        drive(1, 4'b1100, 3, 0, 64'h0000_0000_8000_0001, 0, 2, 1, 0);
        tick();
        check("ldursw", wdata, 64'hFFFF_FFFF_8000_0001);
        mem_ld_signed = 0;
        tick();
        check("ldurw", wdata, 64'h0000_0000_8000_0001);
        drive(1, 4'b1100, 3, 0, 64'hFF, 0, 0, 1, 0);
        tick();
        check("ldsb", wdata, 64'hFFFF_FFFF_FFFF_FFFF);

        // BL and zero register
        drive(1, 4'b1001, 7, 0, 0, 64'h400, 0, 0, 0);
        tick();
        check("bl_reg", wreg, 30);
        check("bl_data", wdata, 64'h400);
        drive(1, 4'b1000, 31, 64'h55, 0, 0, 0, 0, 0);
        tick();
        check("zr_we", we, 0);

        // flags
        drive(1, 4'b0010, 1, 0, 0, 0, 0, 0, 4'b1001);
        tick();
        drive(1, 4'b1000, 2, 0, 0, 0, 0, 0, 4'b0110);
        tick();
        check("flags_set", fout, 4'b1001);
        idle();
        tick();
        check("flags_hold", fout, 4'b1001);

        // stall three cycles, then retire once
        drive(1, 4'b1000, 9, 64'hABCD, 0, 0, 0, 0, 0);
        tick();
        hold_d = wdata; hold_r = wreg;
        idle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", wdata, hold_d);
            check("stall_reg", wreg, hold_r);
            check("stall_we", we, 1);
        end
        stall = 0;
        tick();

        // flush and stall together
        drive(1, 4'b1000, 4, 64'h77, 0, 0, 0, 0, 0);
        tick();
        idle();
        stall = 1; flush = 1;
        tick();
        check("flush_we", we, 0);
        stall = 0; flush = 0;
        tick();

        // reset mid-stall discards the entry
        drive(1, 4'b1010, 6, 64'h99, 0, 0, 0, 0, 4'hF);
        tick();
        stall = 1;
        tick();
        do_reset();

        // 16 retires wrap the narrow counter
        drive(1, 4'b1000, 3, 64'h1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) tick();
        idle();
        tick();
        check("wrap4", cnt4, 0);
        check("wrap32", cnt, 16);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom),
                  5'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  2'($urandom), 1'($urandom), 4'($urandom));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            if (i == 200) begin
                reset_n = 0;
                #1;
                model_reset();
                check("rnd_rst_we", we, 0);
                check("rnd_rst_reg", wreg, 0);
                check("rnd_rst_data", wdata, 0);
                check("rnd_rst_cnt", cnt, 0);
                check("rnd_rst_flags", fout, 0);
                @(posedge clk);
                #1;
                reset_n = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
